// File: rtl/frame_reader.sv
// frame_reader: 640x480@60 VGA scan of a 160x120, 3-bit colour framebuffer.
// Each source pixel is replicated into a 4x4 block. The colour memory is
// external, and it returns rd_data one CLOCK_50 cycle after rd_addr.
//
// Ports:
//   CLOCK_50, resetn    : 50 MHz clock and asynchronous active-low reset
//   rd_addr / rd_data   : framebuffer read port (y*160+x, {R,G,B})
//   VGA_R/G/B           : 10-bit DAC channels, each bit replicated from rd_data
//   VGA_HS/VS           : active-low syncs
//   VGA_BLANK           : high only in the visible region
//   VGA_SYNC            : tied to 1
//   VGA_CLK             : pixel clock (CLOCK_50/2)
//   frame_start         : one-cycle pulse on entry to vertical blank (v 479->480)
//
// Optional feature macro: FRAME_READER_BORDER_EN. When it is defined, the
// outermost source pixels (x=0, x=159, y=0, y=119) are forced to white.
module frame_reader (
    input  logic        CLOCK_50,
    input  logic        resetn,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic        VGA_SYNC,
    output logic        VGA_CLK,
    output logic        frame_start
);

    localparam int unsigned CW           = 10;
    localparam int unsigned AW           = 15;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned H_VIS        = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 751;
    localparam int unsigned V_TOTAL      = 525;
    localparam int unsigned V_VIS        = 480;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 491;
`ifdef FRAME_READER_BORDER_EN
    localparam int unsigned X_MAX        = 159;
    localparam int unsigned Y_MAX        = 119;
`endif

    logic          pix_en_q, pix_en_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          s1_vis_q, s1_vis_d;
    logic          s1_hs_q, s1_hs_d;
    logic          s1_vs_q, s1_vs_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] g_q, g_d;
    logic [CW-1:0] b_q, b_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    logic          frame_start_q, frame_start_d;
`ifdef FRAME_READER_BORDER_EN
    logic          s1_border_q, s1_border_d;
`endif

    logic          visible_c;
    logic [7:0]    x_c;
    logic [7:0]    y_c;
    logic [AW-1:0] addr_c;

    // Scan position decode: 4x4 replication comes from dropping the low two bits.
    always_comb begin
        x_c       = h_q[9:2];
        y_c       = v_q[9:2];
        visible_c = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
        // y*160 + x as two shifts and adds.
        addr_c    = (AW'(y_c) << 7) + (AW'(y_c) << 5) + AW'(x_c);
    end

    // Next-state logic. Stage 1 (address plus sync/blank) and stage 2 (colour)
    // advance only on pixel-enable cycles. Memory data is stable by then.
    always_comb begin
        pix_en_d      = ~pix_en_q;
        h_d           = h_q;
        v_d           = v_q;
        rd_addr_d     = rd_addr_q;
        s1_vis_d      = s1_vis_q;
        s1_hs_d       = s1_hs_q;
        s1_vs_d       = s1_vs_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_d       = blank_q;
        frame_start_d = 1'b0;
`ifdef FRAME_READER_BORDER_EN
        s1_border_d   = s1_border_q;
`endif

        if (pix_en_q) begin
            // Raster counters.
            if (h_q == 10'(H_TOTAL - 1)) begin
                h_d = 10'd0;
                if (v_q == 10'(V_TOTAL - 1)) begin
                    v_d = 10'd0;
                end else begin
                    v_d = v_q + 10'd1;
                end
                frame_start_d = (v_q == 10'(V_VIS - 1));
            end else begin
                h_d = h_q + 10'd1;
            end

            // Stage 1: address fetch and timing flags for the current (h,v).
            rd_addr_d = visible_c ? addr_c : '0;
            s1_vis_d  = visible_c;
            s1_hs_d   = !((h_q >= 10'(H_SYNC_START)) && (h_q <= 10'(H_SYNC_END)));
            s1_vs_d   = !((v_q >= 10'(V_SYNC_START)) && (v_q <= 10'(V_SYNC_END)));
`ifdef FRAME_READER_BORDER_EN
            s1_border_d = visible_c &&
                          ((x_c == 8'd0) || (x_c == 8'(X_MAX)) ||
                           (y_c == 8'd0) || (y_c == 8'(Y_MAX)));
`endif

            // Stage 2: colour from memory, aligned with the delayed flags.
            hs_d    = s1_hs_q;
            vs_d    = s1_vs_q;
            blank_d = s1_vis_q;
            if (s1_vis_q) begin
                r_d = {CW{rd_data[2]}};
                g_d = {CW{rd_data[1]}};
                b_d = {CW{rd_data[0]}};
`ifdef FRAME_READER_BORDER_EN
                if (s1_border_q) begin
                    r_d = '1;
                    g_d = '1;
                    b_d = '1;
                end
`endif
            end else begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end
        end
    end

    // State registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pix_en_q      <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            rd_addr_q     <= '0;
            s1_vis_q      <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef FRAME_READER_BORDER_EN
            s1_border_q   <= 1'b0;
`endif
        end else begin
            pix_en_q      <= pix_en_d;
            h_q           <= h_d;
            v_q           <= v_d;
            rd_addr_q     <= rd_addr_d;
            s1_vis_q      <= s1_vis_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
`ifdef FRAME_READER_BORDER_EN
            s1_border_q   <= s1_border_d;
`endif
        end
    end

    assign rd_addr     = rd_addr_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK   = blank_q;
    assign VGA_SYNC    = 1'b1;
    assign VGA_CLK     = pix_en_q;
    assign frame_start = frame_start_q;

endmodule
